spram_arb: RTL
==============

# spram_arb

Two-requester controller for one single-port block RAM (`spram`, 1-cycle registered read). It time-shares the RAM between a write requester (DDR/AXI loader into the buffer) and a read requester (compute engine), using round-robin arbitration on conflict. It also runs a clear sequence that zero-fills every RAM word after reset or on command. It sits between the loader, the engine and the `spram` instance in the cnna buffer subsystem.

## Interface
Parameters:
- `ASIZE`, 10, RAM address width; depth = 2^ASIZE words.
- `DSIZE`, 32, RAM data width.

Ports:
- `I_clk`  in  1  single clock.
- `I_rst`  in  1  synchronous reset, active-high.
- `I_clr`  in  1  pulse; restarts the zero-fill sequence.
- `O_init_done`  out  1  high while in RUN state.
- `I_wr_req`  in  1  write request; held with addr/data until acked.
- `I_wr_addr`  in  ASIZE  write address.
- `I_wr_data`  in  DSIZE  write data.
- `O_wr_ack`  out  1  combinational; write performed this cycle.
- `I_rd_req`  in  1  read request; held with addr until acked.
- `I_rd_addr`  in  ASIZE  read address.
- `O_rd_ack`  out  1  combinational; read address issued this cycle.
- `O_rd_vld`  out  1  registered; `O_rd_data` valid this cycle.
- `O_rd_data`  out  DSIZE  equals `I_ram_data`.
- `O_ram_addr`  out  ASIZE  to `spram` `I_addr`.
- `O_ram_data`  out  DSIZE  to `spram` `I_data`.
- `O_ram_wr`  out  1  to `spram` `I_wr`.
- `I_ram_data`  in  DSIZE  from `spram` `O_data`.

## Operation
State machine:
- **INIT**
  - Entered on reset, or from any state on the cycle after `I_clr`=1.
  - Each cycle drives `O_ram_wr`=1, `O_ram_addr`=fill counter, `O_ram_data`=0.
  - The counter increments each cycle.
  - After the cycle that writes address 2^ASIZE-1, go to RUN. The counter wraps to 0.
  - `O_wr_ack` and `O_rd_ack` are held at 0 during INIT.
- **RUN**
  - `O_init_done`=1. Arbitrate every cycle.
- `I_clr` during INIT resets the fill counter to 0 on the next cycle and restarts the full fill.
- `I_rst` has priority over `I_clr`.

Arbitration in RUN, combinational on the current-cycle requests:
- Only `I_wr_req`: grant write.
- Only `I_rd_req`: grant read.
- Both requests: grant the side opposite the `last` register.
  - `last` updates only on conflict cycles, to the winner.
  - Reset value of `last` is READ, so the first conflict goes to write.
  - Neither side loses two conflicts in a row.
- Neither request: `O_ram_wr`=0, `O_ram_addr` holds `I_rd_addr` (harmless read), no ack.

Granted cycles:
- Write grant: `O_ram_addr`=`I_wr_addr`, `O_ram_data`=`I_wr_data`, `O_ram_wr`=1, `O_wr_ack`=1.
- Read grant: `O_ram_addr`=`I_rd_addr`, `O_ram_wr`=0, `O_rd_ack`=1.
- `O_ram_data`=`I_wr_data` whenever not in INIT.

Handshake:
- A transfer completes on a req=1 and ack=1 cycle.
- A requester holding req=1 gets back-to-back acks when uncontested, one transfer per ack cycle.
- Requesters must not change addr/data while req=1 and ack=0.

Read return:
- `O_rd_vld` is the registered `O_rd_ack` (cleared by `I_rst` only).
- A read acked in the cycle `I_clr` is high still returns data the next cycle.

## Timing
- Reset values: state=INIT, fill counter=0, `last`=READ, `O_init_done`=0, `O_rd_vld`=0.
- Combinational outputs follow from these values: both acks 0, `O_ram_wr`=1, `O_ram_addr`=0, `O_ram_data`=0 in the first post-reset cycle.
- INIT lasts exactly 2^ASIZE cycles. `O_init_done` rises on cycle 2^ASIZE after reset deassertion, counting the first post-reset cycle as cycle 0.
- Read latency:
  - Ack at cycle t gives `O_rd_vld`=1 and data at t+1.
  - Back-to-back acks give back-to-back valid data.
- Write visibility: a read acked at t+1 or later to a written address returns the new data.
- Throughput: one RAM access per cycle. Under continuous contention each requester gets 50%.
- Reset mid-operation aborts any transfer. A pending `O_rd_vld` is suppressed in the cycle after `I_rst`.

## Test plan
- **Reset/fill, ASIZE=4:** release reset -> addresses 0..15 written with 0 over cycles 0..15, `O_init_done`=1 at cycle 16, no acks before then.
- **Uncontested write then read:** write addr 5 data 0xA5A5A5A5 (ack same cycle); read addr 5 next cycle -> `O_rd_vld`=1 with data 0xA5A5A5A5 one cycle after the read ack.
- **Continuous contention for 6 cycles:** acks alternate W,R,W,R,W,R; the three reads return data on the cycles following their acks.
- **Single streamer:** hold `I_rd_req` for 8 cycles, addr incrementing on each ack -> 8 consecutive acks and 8 consecutive valid outputs.
- **`I_clr` in RUN while a read is acked in that cycle:** `O_rd_vld`=1 next cycle; `O_init_done`=0 from the next cycle; fill restarts at 0; reads afterwards return 0.
- **`I_clr` mid-INIT at counter 7:** counter returns to 0; INIT lasts a full 2^ASIZE more cycles; `I_rst` mid-RUN -> `O_rd_vld`=0 the next cycle and INIT restarts.

Source files
------------

// File: rtl/spram_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : spram_arb                                                        |
// | Purpose : Round-robin write/read arbiter and zero-fill sequencer for one   |
// |           single-port block RAM with a 1-cycle registered read.            |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module spram_arb #(
  parameter int ASIZE = 10,
  parameter int DSIZE = 32
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_clr,
  output logic             O_init_done,
  input  logic             I_wr_req,
  input  logic [ASIZE-1:0] I_wr_addr,
  input  logic [DSIZE-1:0] I_wr_data,
  output logic             O_wr_ack,
  input  logic             I_rd_req,
  input  logic [ASIZE-1:0] I_rd_addr,
  output logic             O_rd_ack,
  output logic             O_rd_vld,
  output logic [DSIZE-1:0] O_rd_data,
  output logic [ASIZE-1:0] O_ram_addr,
  output logic [DSIZE-1:0] O_ram_data,
  output logic             O_ram_wr,
  input  logic [DSIZE-1:0] I_ram_data
);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic             c_LAST_RD   = 1'b0;
  localparam logic             c_LAST_WR   = 1'b1;
  localparam logic [ASIZE-1:0] c_LAST_ADDR = {ASIZE{1'b1}};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ASIZE-1:0]   r_fill_cnt;
  logic               r_last;
  logic               r_rd_vld;
  logic               w_grant_wr;
  logic               w_grant_rd;
  logic               w_conflict;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // On conflict the side that did not win last time gets the RAM.
  always_comb begin
    w_state_nxt = r_state;
    w_conflict  = 1'b0;
    w_grant_wr  = 1'b0;
    w_grant_rd  = 1'b0;
    O_ram_wr    = 1'b0;
    O_ram_addr  = I_rd_addr;
    O_ram_data  = I_wr_data;
    case (r_state)
      S_INIT: begin
        O_ram_wr   = 1'b1;
        O_ram_addr = r_fill_cnt;
        O_ram_data = '0;
        if (r_fill_cnt == c_LAST_ADDR) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_conflict = I_wr_req & I_rd_req;
        w_grant_wr = I_wr_req & (~I_rd_req | (r_last == c_LAST_RD));
        w_grant_rd = I_rd_req & (~I_wr_req | (r_last == c_LAST_WR));
        if (w_grant_wr) begin
          O_ram_wr   = 1'b1;
          O_ram_addr = I_wr_addr;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
    if (I_clr) begin
      w_state_nxt = S_INIT;
    end
  end

  // Counter wraps to zero as the fill completes, so RUN always holds it at 0.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_fill_cnt <= '0;
    end else if (I_clr) begin
      r_fill_cnt <= '0;
    end else if (r_state == S_INIT) begin
      r_fill_cnt <= r_fill_cnt + 1'b1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_last <= c_LAST_RD;
    end else if (w_conflict) begin
      r_last <= w_grant_wr ? c_LAST_WR : c_LAST_RD;
    end
  end

  // A read acked in the same cycle as I_clr still returns its data.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= w_grant_rd;
    end
  end

  assign O_init_done = (r_state == S_RUN);
  assign O_wr_ack    = w_grant_wr;
  assign O_rd_ack    = w_grant_rd;
  assign O_rd_vld    = r_rd_vld;
  assign O_rd_data   = I_ram_data;

endmodule
`default_nettype wire
